rpn_stack_sequencer: RTL
========================

// Module: rpn_stack_sequencer
// PURPOSE
//  Sequencer for the 4x4-bit register stack. Accepts RPN tokens (literal, arithmetic op,
//  exchange, drop) over a valid/ready handshake and turns each into one-cycle push/pop/exch
//  command pulses. Checks stack depth before every command. Sits between keypad decode and stack.
// PARAMETERS
//  W      4  data width of a stack entry and of literals
//  DEPTH  4  stack capacity; a push at this depth is an overflow
//  DW     3  width of stk_depth (holds 0..DEPTH)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-low
//  tok_valid  in   1   token present
//  tok_ready  out  1   sequencer can accept a token (IDLE only)
//  tok_kind   in   2   00 literal, 01 op, 10 exch, 11 drop
//  tok_data   in   W   literal value (kind 00) / op code in [1:0] (kind 01)
//  stk_push   out  1   one-cycle push pulse to the stack
//  stk_pop    out  1   one-cycle pop pulse
//  stk_exch   out  1   one-cycle exchange pulse (swap top two entries)
//  stk_din    out  W   push data, valid while stk_push=1
//  stk_top    in   W   current top-of-stack entry
//  stk_nxt    in   W   entry below top
//  stk_depth  in   DW  number of entries held (0..DEPTH)
//  res        out  W   last ALU result
//  res_valid  out  1   one-cycle pulse with the result push
//  carry      out  1   carry (add) / borrow (sub) of the last op; 0 for and/xor
//  err_over   out  1   sticky: literal rejected, stack full
//  err_under  out  1   sticky: op/exch/drop rejected, too few entries
//  clr_err    in   1   clears both sticky flags
// BEHAVIOUR
//  Reset: state IDLE. tok_ready=1. All outputs 0: stk_*, res, res_valid, carry, err_*.
//   Takes priority over everything in the same cycle, including mid-sequence. A
//   partially issued op is abandoned; the stack is reset by its own rst.
//  Handshake: a token is accepted at edge T when tok_valid & tok_ready. Otherwise no effect.
//  At most one of stk_push/stk_pop/stk_exch is high in any cycle.
//  Every command pulse is followed by one WAIT cycle so stk_depth/top settle.
//  Op codes: 00 add, 01 sub, 10 and, 11 xor.
//   Operands: A=stk_nxt, B=stk_top. sub computes A-B (RPN order).
//   Arithmetic is W-bit wrap. carry = bit W of the (W+1)-bit sum or borrow.
//  FSM states: IDLE, LOAD, POP1, W1, POP2, W2, PUSH, WAIT.
//   literal: depth==DEPTH -> err_over, stay IDLE.
//     Else PUSH(T+1, stk_din=tok_data), WAIT(T+2), IDLE(T+3).
//   exch: depth<2 -> err_under. Else stk_exch at T+1, WAIT, IDLE at T+3.
//   drop: depth==0 -> err_under. Else stk_pop at T+1, WAIT, IDLE at T+3.
//   op: depth<2 -> err_under. Else the sequence below; tok_ready returns at T+8.
//     T+1 LOAD: latch res and carry from the current stk_top/stk_nxt.
//     T+2 POP1, T+3 W1, T+4 POP2, T+5 W2.
//     T+6 PUSH: stk_din=res, res_valid=1. T+7 WAIT. T+8 IDLE.
//  Rejected token: consumed, no stack command, flag set on edge T+1.
//   tok_ready stays 1 and stack contents are unchanged.
//  clr_err in the same cycle as a new error: the error wins (flag stays 1).
//  res and carry hold until the next op completes LOAD. Flags persist across ops.
// STRUCTURE
//  Shared package rpn_pkg holds:
//   - tok_kind codes TK_LIT/TK_OP/TK_EXCH/TK_DROP
//   - op codes OP_ADD/OP_SUB/OP_AND/OP_XOR
//   - FSM state encoding
//  One sub-module: rpn_alu, combinational (a,b,op) -> (y,carry). Instanced once at LOAD input.
//  Single FSM plus a res/carry register and the two sticky flag registers.
// TESTING
//  1 Reset, then push literals 3,5, then op add.
//    -> stk_push with stk_din=8 at T+6, res_valid=1, carry=0, depth ends at 1.
//  2 Depth 2 with nxt=2, top=5, op sub.
//    -> res=4'hD, carry=1. Exactly two stk_pop pulses, then one stk_push.
//  3 Push 4 literals, then a 5th.
//    -> no stk_push, err_over=1 at T+1, tok_ready=1.
//  4 Depth 1, then op and exch.
//    -> err_under=1, no command pulses. clr_err -> 0.
//    clr_err in the same cycle as a new underflow -> err_under stays 1.
//  5 rst=0 at T+3 of an op.
//    -> all outputs 0 next edge, IDLE, tok_ready=1; no later push.
//  6 tok_valid held high with back-to-back literals 1,2.
//    -> accepts spaced 3 cycles apart; no two command pulses adjacent.

Source files
------------

// File: rtl/rpn_stack_sequencer_pkg.sv
// Shared codes for the RPN stack sequencer: token kinds, ALU op codes, FSM encoding.
package rpn_pkg;

    localparam logic [1:0] TK_LIT  = 2'b00;
    localparam logic [1:0] TK_OP   = 2'b01;
    localparam logic [1:0] TK_EXCH = 2'b10;
    localparam logic [1:0] TK_DROP = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_POP1 = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_POP2 = 3'd4;
    localparam logic [2:0] S_W2   = 3'd5;
    localparam logic [2:0] S_PUSH = 3'd6;
    localparam logic [2:0] S_WAIT = 3'd7;

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// Token handshake from keypad decode into the sequencer.
interface rpn_stack_sequencer_if #(
    parameter int W = 4
);
    logic         tok_valid;
    logic         tok_ready;
    logic [1:0]   tok_kind;
    logic [W-1:0] tok_data;

    modport master (output tok_valid, tok_kind, tok_data, input tok_ready);
    modport slave  (input tok_valid, tok_kind, tok_data, output tok_ready);
endinterface

// File: rtl/rpn_stack_sequencer_alu.sv
// Combinational W-bit ALU; carry is bit W of the widened add / subtract (borrow).
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] y_o,
    output logic         carry_o
);
    logic [W:0] r;

    always_comb begin
        r = '0;
        case (op_i)
            OP_ADD:  r = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  r = {1'b0, a_i} - {1'b0, b_i};
            OP_AND:  r = {1'b0, a_i & b_i};
            default: r = {1'b0, a_i ^ b_i};
        endcase
    end

    assign y_o     = r[W-1:0];
    assign carry_o = r[W];
endmodule

// File: rtl/rpn_stack_sequencer.sv
// Turns RPN tokens into spaced push/pop/exch pulses for a small register stack,
// with depth checks, an ALU result register and sticky over/underflow flags.
module rpn_stack_sequencer
    import rpn_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    rpn_stack_sequencer_if.slave  tok_if,
    output logic                  stk_push_o,
    output logic                  stk_pop_o,
    output logic                  stk_exch_o,
    output logic [W-1:0]          stk_din_o,
    input  logic [W-1:0]          stk_top_i,
    input  logic [W-1:0]          stk_nxt_i,
    input  logic [DW-1:0]         stk_depth_i,
    output logic [W-1:0]          res_o,
    output logic                  res_valid_o,
    output logic                  carry_o,
    output logic                  err_over_o,
    output logic                  err_under_o,
    input  logic                  clr_err_i
);
    logic [2:0]   state_q, state_d;
    logic [1:0]   kind_q, kind_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] lit_q, lit_d;
    logic [W-1:0] res_q, res_d;
    logic         carry_q, carry_d;
    logic         over_q, over_d;
    logic         under_q, under_d;
    logic         set_over, set_under, accept;
    logic [W-1:0] alu_y;
    logic         alu_c;

    rpn_alu #(.W(W)) u_alu (
        .a_i     (stk_nxt_i),
        .b_i     (stk_top_i),
        .op_i    (op_q),
        .y_o     (alu_y),
        .carry_o (alu_c)
    );

    assign accept = tok_if.tok_valid && (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        op_d      = op_q;
        lit_d     = lit_q;
        res_d     = res_q;
        carry_d   = carry_q;
        set_over  = 1'b0;
        set_under = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                kind_d = tok_if.tok_kind;
                case (tok_if.tok_kind)
                    TK_LIT: if (stk_depth_i == DW'(DEPTH)) set_over = 1'b1;
                            else begin lit_d = tok_if.tok_data; state_d = S_PUSH; end
                    TK_OP:  if (stk_depth_i < DW'(2)) set_under = 1'b1;
                            else begin op_d = tok_if.tok_data[1:0]; state_d = S_LOAD; end
                    TK_EXCH: if (stk_depth_i < DW'(2)) set_under = 1'b1;
                             else state_d = S_POP1;
                    default: if (stk_depth_i == '0) set_under = 1'b1;
                             else state_d = S_POP1;
                endcase
            end
            S_LOAD: begin
                res_d   = alu_y;
                carry_d = alu_c;
                state_d = S_POP1;
            end
            // POP1 doubles as the single-command cycle for exch and drop
            S_POP1:  state_d = (kind_q == TK_OP) ? S_W1 : S_WAIT;
            S_W1:    state_d = S_POP2;
            S_POP2:  state_d = S_W2;
            S_W2:    state_d = S_PUSH;
            S_PUSH:  state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
        over_d  = set_over  | (over_q  & ~clr_err_i);
        under_d = set_under | (under_q & ~clr_err_i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kind_q  <= TK_LIT;
            op_q    <= OP_ADD;
            lit_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            op_q    <= op_d;
            lit_q   <= lit_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            over_q  <= over_d;
            under_q <= under_d;
        end
    end

    assign tok_if.tok_ready = (state_q == S_IDLE);
    assign stk_push_o  = (state_q == S_PUSH);
    assign stk_exch_o  = (state_q == S_POP1) && (kind_q == TK_EXCH);
    assign stk_pop_o   = ((state_q == S_POP1) && (kind_q != TK_EXCH)) || (state_q == S_POP2);
    assign stk_din_o   = stk_push_o ? ((kind_q == TK_OP) ? res_q : lit_q) : '0;
    assign res_valid_o = stk_push_o && (kind_q == TK_OP);
    assign res_o       = res_q;
    assign carry_o     = carry_q;
    assign err_over_o  = over_q;
    assign err_under_o = under_q;
endmodule
